// File: rtl/mbrt_pkg.sv
// mbrt_pkg: shared widths, shift amounts, the three constant-angle
// rotation coefficient tables and the output saturation helper for the
// MBRT fine-rotation stage.
//
// Tables hold round(16384*cos(k*w)) / round(16384*sin(k*w)) for k = 0..7:
//   BLK_FINE   : w = 0.703125 deg  (phase bits [2:0])
//   BLK_MID    : w = 5.625 deg     (phase bits [5:3])
//   BLK_COARSE : w = 45 deg        (phase bits [8:6])
package mbrt_pkg;

  localparam int unsigned CW     = 20;  // coarse/output width, Q1.19
  localparam int unsigned FW     = 12;  // fine input width, Q1.11
  localparam int unsigned IW     = 14;  // rotated-vector width
  localparam int unsigned KW     = 16;  // coefficient width, Q2.14
  localparam int unsigned ROT_SH = 14;  // coefficient scaling shift
  localparam int unsigned ALN_SH = 8;   // fine-to-coarse alignment shift
  localparam int          ROT_RND = 8192;  // half LSB after ROT_SH

  typedef enum logic [1:0] {
    BLK_FINE   = 2'd0,
    BLK_MID    = 2'd1,
    BLK_COARSE = 2'd2
  } blk_sel_e;

  typedef logic signed [KW-1:0] coef_t;

  localparam coef_t COS_TAB [3][8] = '{
    '{16'sd16384, 16'sd16383, 16'sd16379, 16'sd16373,
      16'sd16364, 16'sd16353, 16'sd16340, 16'sd16324},
    '{16'sd16384, 16'sd16305, 16'sd16069, 16'sd15679,
      16'sd15137, 16'sd14449, 16'sd13623, 16'sd12665},
    '{16'sd16384, 16'sd11585, 16'sd0,     -16'sd11585,
      -16'sd16384, -16'sd11585, 16'sd0,   16'sd11585}
  };

  localparam coef_t SIN_TAB [3][8] = '{
    '{16'sd0,     16'sd201,   16'sd402,   16'sd603,
      16'sd804,   16'sd1005,  16'sd1205,  16'sd1406},
    '{16'sd0,     16'sd1606,  16'sd3196,  16'sd4756,
      16'sd6270,  16'sd7723,  16'sd9102,  16'sd10394},
    '{16'sd0,     16'sd11585, 16'sd16384, 16'sd11585,
      16'sd0,     -16'sd11585, -16'sd16384, -16'sd11585}
  };

  // Clamp a CW+2 bit sum into the signed CW-bit output range.
  function automatic logic signed [CW-1:0] sat20(input logic signed [CW+1:0] v);
    logic signed [CW+1:0] max_v;
    logic signed [CW+1:0] min_v;
    max_v = $signed({3'b000, {(CW-1){1'b1}}});
    min_v = $signed({3'b111, {(CW-1){1'b0}}});
    if (v > max_v)
      return max_v[CW-1:0];
    else if (v < min_v)
      return min_v[CW-1:0];
    else
      return v[CW-1:0];
  endfunction

endpackage

// File: rtl/mbrt_rot_stage.sv
// mbrt_rot_stage: one combinational, enable-gated constant-angle rotation.
//   TSEL  : which coefficient table (angle weight) this block uses
//   i_en  : 1 = rotate by i_seg * weight, 0 = pass input through
//   i_seg : 3-bit angle segment
//   i_x/i_y : input vector (IW bits, signed)
//   o_x/o_y : rotated vector, round-half-up, IW bits signed
module mbrt_rot_stage
  import mbrt_pkg::*;
#(
  parameter blk_sel_e TSEL = BLK_FINE
) (
  input  logic                 i_en,
  input  logic [2:0]           i_seg,
  input  logic signed [IW-1:0] i_x,
  input  logic signed [IW-1:0] i_y,
  output logic signed [IW-1:0] o_x,
  output logic signed [IW-1:0] o_y
);

  logic signed [31:0] w_x;
  logic signed [31:0] w_y;
  logic signed [31:0] w_c;
  logic signed [31:0] w_s;
  logic signed [31:0] w_xf;
  logic signed [31:0] w_yf;

  always_comb begin
    w_x  = 32'(i_x);
    w_y  = 32'(i_y);
    w_c  = 32'(COS_TAB[TSEL][i_seg]);
    w_s  = 32'(SIN_TAB[TSEL][i_seg]);
    w_xf = w_x * w_c - w_y * w_s + ROT_RND;
    w_yf = w_x * w_s + w_y * w_c + ROT_RND;
    // |input| <= 2897 keeps the rotated result well inside IW bits.
    o_x  = i_en ? IW'(w_xf >>> ROT_SH) : i_x;
    o_y  = i_en ? IW'(w_yf >>> ROT_SH) : i_y;
  end

endmodule

// File: rtl/mbrt_rot.sv
// mbrt_rot: MBRT DDFS fine-rotation stage. Rotates the fine vector through
// three cascaded constant-angle blocks, aligns it to the coarse format and
// adds it to the coarse vector with saturation. Two-cycle latency, one
// sample per clock, no handshake.
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset
//   xc, yc  : coarse cos/sin, signed Q1.19
//   xp, yp  : fine vector, signed Q1.11
//   phi_rot : segments [2:0] block1, [5:3] block2, [8:6] block3
//   en      : en[k] enables block k+1; all zero bypasses the fine path
//   xs, ys  : synthesized cos/sin, signed Q1.19
module mbrt_rot
  import mbrt_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [CW-1:0] xc,
  input  logic signed [CW-1:0] yc,
  input  logic signed [FW-1:0] xp,
  input  logic signed [FW-1:0] yp,
  input  logic [8:0]           phi_rot,
  input  logic [2:0]           en,
  output logic signed [CW-1:0] xs,
  output logic signed [CW-1:0] ys
);

  logic signed [IW-1:0] w_x0, w_y0;
  logic signed [IW-1:0] w_x1, w_y1;
  logic signed [IW-1:0] w_x2, w_y2;
  logic signed [IW-1:0] w_x3, w_y3;

  logic signed [IW-1:0] r_xr, r_yr;
  logic signed [CW-1:0] r_xc, r_yc;
  logic                 r_any_en;

  logic signed [CW+1:0] w_sum_x, w_sum_y;

  assign w_x0 = IW'(xp);
  assign w_y0 = IW'(yp);

  mbrt_rot_stage #(.TSEL(BLK_FINE)) u_blk1 (
    .i_en  (en[0]),
    .i_seg (phi_rot[2:0]),
    .i_x   (w_x0),
    .i_y   (w_y0),
    .o_x   (w_x1),
    .o_y   (w_y1)
  );

  mbrt_rot_stage #(.TSEL(BLK_MID)) u_blk2 (
    .i_en  (en[1]),
    .i_seg (phi_rot[5:3]),
    .i_x   (w_x1),
    .i_y   (w_y1),
    .o_x   (w_x2),
    .o_y   (w_y2)
  );

  mbrt_rot_stage #(.TSEL(BLK_COARSE)) u_blk3 (
    .i_en  (en[2]),
    .i_seg (phi_rot[8:6]),
    .i_x   (w_x2),
    .i_y   (w_y2),
    .o_x   (w_x3),
    .o_y   (w_y3)
  );

  // Stage 1: rotated vector plus the coarse vector delayed to match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_xr     <= '0;
      r_yr     <= '0;
      r_xc     <= '0;
      r_yc     <= '0;
      r_any_en <= 1'b0;
    end else begin
      r_xr     <= w_x3;
      r_yr     <= w_y3;
      r_xc     <= xc;
      r_yc     <= yc;
      r_any_en <= |en;
    end
  end

  assign w_sum_x = (CW+2)'(r_xc) + ((CW+2)'(r_xr) <<< ALN_SH);
  assign w_sum_y = (CW+2)'(r_yc) + ((CW+2)'(r_yr) <<< ALN_SH);

  // Stage 2: with no block enabled the coarse vector passes unmodified.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xs <= '0;
      ys <= '0;
    end else begin
      xs <= r_any_en ? sat20(w_sum_x) : r_xc;
      ys <= r_any_en ? sat20(w_sum_y) : r_yc;
    end
  end

endmodule

// File: tb/tb_mbrt_rot.sv
module tb_mbrt_rot;

  logic               clk;
  logic               rst_n;
  logic signed [19:0] xc, yc;
  logic signed [11:0] xp, yp;
  logic [8:0]         phi;
  logic [2:0]         en;
  logic signed [19:0] xs, ys;

  int checks = 0;
  int errors = 0;

  int ctab [3][8];
  int stab [3][8];

  typedef struct {
    int    ex;
    int    ey;
    string tag;
  } exp_t;

  exp_t q[$];

  mbrt_rot dut (
    .clk     (clk),
    .reset   (rst_n),
    .xc      (xc),
    .yc      (yc),
    .xp      (xp),
    .yp      (yp),
    .phi_rot (phi),
    .en      (en),
    .xs      (xs),
    .ys      (ys)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else          return -$rtoi(-r + 0.5);
  endfunction

  function automatic int clamp20(input longint v);
    if (v > 524287)  return 524287;
    if (v < -524288) return -524288;
    return int'(v);
  endfunction

  // Reference: rotate by sum of enabled segment angles, then align and add.
  function automatic void model(input int cx, input int cy, input int px, input int py,
                                input logic [8:0] ph, input logic [2:0] e,
                                output int ex, output int ey);
    longint x, y, nx, ny;
    int k;
    x = px;
    y = py;
    for (int b = 0; b < 3; b++) begin
      if (e[b]) begin
        k  = int'(ph[3*b +: 3]);
        nx = (x * ctab[b][k] - y * stab[b][k] + 8192) >>> 14;
        ny = (x * stab[b][k] + y * ctab[b][k] + 8192) >>> 14;
        x  = nx;
        y  = ny;
      end
    end
    if (e != 3'b000) begin
      ex = clamp20(longint'(cx) + x * 256);
      ey = clamp20(longint'(cy) + y * 256);
    end else begin
      ex = cx;
      ey = cy;
    end
  endfunction

  task automatic check_out(input string tag, input int ex, input int ey);
    checks++;
    assert (int'(xs) === ex) else begin
      errors++;
      $error("FAIL %s xs: got %0d expected %0d", tag, xs, ex);
    end
    checks++;
    assert (int'(ys) === ey) else begin
      errors++;
      $error("FAIL %s ys: got %0d expected %0d", tag, ys, ey);
    end
  endtask

  // One sample per falling edge; the result for a sample is checked two
  // falling edges after it is applied.
  task automatic drive(input string tag, input int cx, input int cy, input int px,
                       input int py, input logic [8:0] ph, input logic [2:0] e);
    exp_t t;
    @(negedge clk);
    if (q.size() == 2) begin
      t = q.pop_front();
      check_out(t.tag, t.ex, t.ey);
    end
    xc  = 20'(cx);
    yc  = 20'(cy);
    xp  = 12'(px);
    yp  = 12'(py);
    phi = ph;
    en  = e;
    model(cx, cy, px, py, ph, e, t.ex, t.ey);
    t.tag = tag;
    q.push_back(t);
  endtask

  task automatic drive_rand(input int n);
    for (int i = 0; i < n; i++)
      drive("rand",
            int'($signed(20'($urandom))), int'($signed(20'($urandom))),
            int'($signed(12'($urandom))), int'($signed(12'($urandom))),
            9'($urandom), 3'($urandom));
  endtask

  task automatic release_reset();
    exp_t z;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    z.ex  = 0;
    z.ey  = 0;
    z.tag = "post_reset_zero";
    q.push_back(z);
  endtask

  initial begin
    real pi;
    real w [3];
    pi   = 3.14159265358979;
    w[0] = 0.703125 * pi / 180.0;
    w[1] = 5.625 * pi / 180.0;
    w[2] = 45.0 * pi / 180.0;
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < 8; k++) begin
        ctab[b][k] = rnd(16384.0 * $cos(k * w[b]));
        stab[b][k] = rnd(16384.0 * $sin(k * w[b]));
      end

    rst_n = 1'b0;
    xc = '0; yc = '0; xp = '0; yp = '0; phi = '0; en = '0;

    // Held in reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      xc  = 20'($urandom);
      yc  = 20'($urandom);
      xp  = 12'($urandom);
      yp  = 12'($urandom);
      phi = 9'($urandom);
      en  = 3'($urandom);
      @(negedge clk);
      check_out("in_reset", 0, 0);
    end

    // Release: the drive in the same falling edge is the first sample,
    // the preceding output must still read zero.
    release_reset();
    xc = 20'sd1000; yc = -20'sd5; xp = 12'sd1024; yp = 12'sd512;
    phi = 9'b101_011_110; en = 3'b000;
    begin
      exp_t t0;
      t0.ex = 1000; t0.ey = -5; t0.tag = "bypass";
      q.push_back(t0);
    end

    drive("ident_seg0", 0, 0, 1024, 512, 9'b000_000_000, 3'b001);
    drive("rot45",      0, 0, 1024, 512, 9'b001_000_000, 3'b100);
    drive("rot90_dis",  0, 0, 1024, 512, 9'b010_111_111, 3'b100);
    drive("sat_pos",    524287, 0, 1024, 512, 9'b000_000_000, 3'b100);
    drive("sat_neg",    -524288, -524288, -2048, -2048, 9'b100_000_000, 3'b100);
    drive("all_blocks", 12345, -54321, 777, -1500, 9'b011_101_111, 3'b111);
    drive("fine_only",  0, 0, 2047, -2048, 9'b000_000_111, 3'b001);
    drive("mid_only",   -3, 7, -1000, 2000, 9'b000_110_000, 3'b010);
    drive_rand(200);

    // Asynchronous reset mid-stream, asserted between clock edges.
    drive("pre_areset", 300000, -300000, 1024, 512, 9'b000_000_000, 3'b100);
    drive("pre_areset", 300000, -300000, 1024, 512, 9'b000_000_000, 3'b100);
    drive("pre_areset", 300000, -300000, 1024, 512, 9'b000_000_000, 3'b100);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 0, 0);
    @(negedge clk);
    check_out("async_reset_hold", 0, 0);

    release_reset();
    xc = -20'sd77; yc = 20'sd88; xp = '0; yp = '0; phi = '0; en = 3'b000;
    begin
      exp_t t1;
      t1.ex = -77; t1.ey = 88; t1.tag = "restart_first";
      q.push_back(t1);
    end
    drive_rand(40);
    drive("drain", 0, 0, 0, 0, 9'd0, 3'b000);
    drive("drain", 0, 0, 0, 0, 9'd0, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbrt_rot.md
Name: mbrt_rot

Overview:
Fine-rotation stage of the multi-block rotation (MBRT) DDFS datapath.
- A fine vector (xp, yp) is rotated through up to three cascaded constant-angle rotation blocks selected by a 9-bit phase word.
- The rotated vector is aligned to the coarse LUT amplitude format and added to the coarse vector (xc, yc), producing the synthesized sine/cosine pair (xs, ys).
- Sits between the coarse LUT and the DDFS output register.

Parameters:
- CW, 20, coarse/output width (signed, Q1.19)
- FW, 12, fine input width (signed, Q1.11)
- IW, 14, internal rotated-vector width (signed)
- KW, 16, coefficient width (signed Q2.14; 1.0 = 16384)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- xc  in  20  coarse x (cos), signed Q1.19
- yc  in  20  coarse y (sin), signed Q1.19
- xp  in  12  fine x, signed Q1.11
- yp  in  12  fine y, signed Q1.11
- phi_rot  in  9  rotation angle: [2:0] block1, [5:3] block2, [8:6] block3
- en  in  3  en[k] enables block k+1
- xs  out  20  result x, signed Q1.19
- ys  out  20  result y, signed Q1.19

Behaviour:
- Reset (reset=0, asynchronous): all pipeline registers and xs, ys go to 0 immediately. They stay 0 while reset is low.
- Angle weights (9-bit phase, LSB = 360/512 deg):
  - block3 = s3*45 deg
  - block2 = s2*5.625 deg
  - block1 = s1*0.703125 deg
- Each block has an 8-entry constant ROM: c = round(16384*cos(k*w)), s = round(16384*sin(k*w)). Example for block3: k=1 gives c=s=11585; k=2 gives c=0, s=16384.
- Block operation, enabled: x' = (x*c - y*s + 8192) >>> 14 and y' = (x*s + y*c + 8192) >>> 14. Arithmetic shift, i.e. round half up. Results are held in IW bits; no overflow is possible because |v| <= 2897.
- Block operation, disabled (en bit = 0): the block passes its input unchanged and its segment is ignored. Segment 0 with the block enabled is also an identity.
- Chain order: sign-extend (xp, yp) to IW, then block1, block2, block3. All three blocks are combinational within stage 1.
- Cycle 1 register: rotated vector (xr, yr), plus xc, yc and the flag any_en = |en.
- Cycle 2 register (outputs):
  - any_en = 1: xs = sat20(xc + (xr <<< 8)) and ys = sat20(yc + (yr <<< 8)), computed at 22-bit precision.
  - any_en = 0: xs = xc and ys = yc. The fine path is bypassed entirely; there is no fine contribution.
- sat20 clamps to the range [-524288, 524287].
- Latency: exactly 2 cycles from input sample edge to output. Throughput is one sample per clock. There is no handshake; inputs are sampled every rising edge.
- Inputs changing every cycle are fully pipelined and independent per sample, including en and phi_rot.
- Reset released mid-stream: the first valid output appears 2 edges after the first sampled input. Before that, the outputs read 0.

Decomposition:
- Package mbrt_pkg holds:
  - width constants CW, FW, IW, KW, and the shift values 14 and 8
  - the three 8x2 coefficient tables as constant arrays
  - the sat20 function
- One sub-module, mbrt_rot_stage: a single enable-gated rotation block. It is parameterized by a table selector, takes a 3-bit segment, and is combinational. It is instantiated three times.

Test Plan:
- Reset: hold reset=0 with random inputs -> xs=0, ys=0. Drive reset low mid-stream -> outputs go to 0 asynchronously, before the next edge.
- Bypass: xc=1000, yc=-5, xp=1024, yp=512, en=000, any phi -> after 2 cycles xs=1000, ys=-5.
- Identity via segment 0: xc=yc=0, xp=1024, yp=512, en=001, phi=0 -> xs=262144, ys=131072.
- 45 deg: xc=yc=0, xp=1024, yp=512, en=100, phi=001_000_000 -> xs=92672 (362<<8), ys=278016 (1086<<8).
- 90 deg plus disabled-segment check: same vector, en=100, phi=010_111_111 -> xs=-131072, ys=262144. Blocks 1 and 2 are disabled, so their segments are ignored.
- Saturation and pipelining:
  - xc=524287, yc=0, xp=1024, yp=512, en=100, phi=0 -> xs=524287 (clamped), ys=131072.
  - Back-to-back differing vectors on consecutive cycles -> each result appears exactly 2 cycles after its input.
